// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame width and default timing.
// Used by both the RX and TX stages.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned DEFAULT_TICK_DIV   = 54;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider; clr restarts the count so the
// sampling phase can be aligned to an external event.
module uart_baud_tick #(
    parameter int unsigned TICK_DIV = uart_pkg::DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_div <= '0;
        end else if (r_div == LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + W'(1);
        end
    end

    assign tick = (r_div == LAST) && !clr;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver: 2-FF input synchronizer, tick divider
// aligned to the start edge, and a single registered FSM for framing.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned TICK_DIV   = DEFAULT_TICK_DIV,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 done,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t          r_state;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [SW-1:0]        r_smp;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_done;
    logic                 r_frame_err;
    logic                 r_busy;
    logic                 w_tick;
    logic                 w_clr;
    logic                 w_mid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Divider restarts on the same cycle the start edge is detected.
    assign w_clr = (r_state == ST_IDLE) && !r_rx_s;
    assign w_mid = w_tick && (r_smp == MID);

    uart_baud_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .tick(w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_smp       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_dout      <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            // Sample counter runs continuously from the start edge, so each
            // later bit midpoint lands exactly OVERSAMPLE ticks after the last.
            if (r_state != ST_IDLE && w_tick) begin
                r_smp <= r_smp + SW'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_state   <= ST_START;
                        r_smp     <= '0;
                        r_bit_idx <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_mid) begin
                        if (r_rx_s) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_mid) begin
                        r_shreg   <= {r_rx_s, r_shreg[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_mid) begin
                        if (r_rx_s) begin
                            r_dout  <= r_shreg;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (w_tick && r_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dout      = r_dout;
    assign done      = r_done;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os at TICK_DIV=4, OVERSAMPLE=16 (64 clk/bit).
module tb_uart_rx_os;

    localparam int unsigned BIT = 64;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] dout;
    logic       done;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;
    logic done_prev = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_os #(
        .TICK_DIV  (4),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .dout     (dout),
        .done     (done),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (done || frame_err) begin
                checks++;
                if (done && frame_err) begin
                    failures++;
                    $display("FAIL exclusive: done=%b frame_err=%b required not both high", done, frame_err);
                end
            end
            if (done) begin
                done_cnt++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                checks++;
                if (done_prev) begin
                    failures++;
                    $display("FAIL done_width: done high on consecutive cycles, required 1 clk");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: dout=%02h with no frame expected", dout);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (dout !== e) begin
                        failures++;
                        $display("FAIL dout: got %02h required %02h", dout, e);
                    end
                end
            end
            if (frame_err) ferr_cnt++;
        end
        done_prev = done;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        if (stop) exp_q.push_back(d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) wait_clks(1);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d frames outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        int d0, f0;
        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(5);
        checks++;
        if (dout !== 8'h00 || done !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset: dout=%02h done=%b ferr=%b busy=%b required 00 0 0 0", dout, done, frame_err, busy);
        end
        rst = 1'b0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        wait_clks(1000);
        checks++;
        if (done_cnt != d0 || ferr_cnt != f0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle: done=%0d ferr=%0d busy=%b required 0 0 0", done_cnt - d0, ferr_cnt - f0, busy);
        end
    endtask

    task automatic test_single;
        int d0, f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'hF1, 1'b1);
        drain("single");
        wait_clks(4);
        checks++;
        if (done_cnt - d0 != 1 || ferr_cnt != f0) begin
            failures++;
            $display("FAIL single_count: done=%0d ferr=%0d required 1 0", done_cnt - d0, ferr_cnt - f0);
        end
        checks++;
        if (dout !== 8'hF1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_out: dout=%02h busy=%b required F1 0", dout, busy);
        end
    endtask

    task automatic test_back_to_back;
        int d0, gap;
        d0 = done_cnt;
        send_frame(8'h02, 1'b1);
        send_frame(8'hA5, 1'b1);
        drain("b2b");
        wait_clks(4);
        gap = last_done_cyc - prev_done_cyc;
        checks++;
        if (done_cnt - d0 != 2) begin
            failures++;
            $display("FAIL b2b_count: done=%0d required 2", done_cnt - d0);
        end
        checks++;
        if (gap < 638 || gap > 642) begin
            failures++;
            $display("FAIL b2b_gap: got %0d clk required 640+/-2", gap);
        end
        checks++;
        if (dout !== 8'hA5) begin
            failures++;
            $display("FAIL b2b_dout: got %02h required A5", dout);
        end
    endtask

    task automatic test_glitch;
        int d0, f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        wait_clks(5);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy: busy=%b required 1", busy);
        end
        wait_clks(15);
        rx = 1'b1;
        wait_clks(200);
        checks++;
        if (busy !== 1'b0 || done_cnt != d0 || ferr_cnt != f0 || dout !== 8'hA5) begin
            failures++;
            $display("FAIL glitch: busy=%b done=%0d ferr=%0d dout=%02h required 0 0 0 A5", busy, done_cnt - d0, ferr_cnt - f0, dout);
        end
    endtask

    task automatic test_frame_err;
        int d0, f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        wait_clks(3 * BIT);
        checks++;
        if (busy !== 1'b1 || ferr_cnt - f0 != 1) begin
            failures++;
            $display("FAIL break_hold: busy=%b ferr=%0d required 1 1", busy, ferr_cnt - f0);
        end
        rx = 1'b1;
        wait_clks(100);
        checks++;
        if (busy !== 1'b0 || ferr_cnt - f0 != 1 || done_cnt != d0 || dout !== 8'hA5) begin
            failures++;
            $display("FAIL break_exit: busy=%b ferr=%0d done=%0d dout=%02h required 0 1 0 A5", busy, ferr_cnt - f0, done_cnt - d0, dout);
        end
    endtask

    task automatic test_reset_mid_frame;
        int d0;
        logic [7:0] d;
        d0 = done_cnt;
        d = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(1);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst: busy=%b done=%b required 0 0", busy, done);
        end
        rst = 1'b0;
        wait_clks(100);
        send_frame(8'hC3, 1'b1);
        drain("post_rst");
        wait_clks(4);
        checks++;
        if (dout !== 8'hC3 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL post_rst: dout=%02h done=%0d required C3 1", dout, done_cnt - d0);
        end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_mid_frame;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard: %0d entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
